// File: rtl/clock_pkg.sv
// Shared timekeeping constants: field ranges and widths for the clock, alarm and display blocks.
package clock_pkg;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;
  localparam int H12_W  = 4;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

endpackage

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) up-counter with synchronous clear; wrap flags the increment that returns q to zero.
module mod_counter #(
  parameter int MAX = 59,
  parameter int W   = 6
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         wrap
);

  localparam logic [W-1:0] MAX_Q = W'(MAX);

  assign wrap = inc && (q == MAX_Q);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= wrap ? '0 : q + W'(1);
    end
  end

endmodule

// File: rtl/time_counter.sv
// 24-hour timekeeper with per-field time setting, 12-hour view, minute carry pulse and hourly chime.
module time_counter
  import clock_pkg::*;
#(
  parameter int CHIME_LEN = 5,
  parameter int CHIME_EN  = 1
) (
  input  logic              CP_1Hz,
  input  logic              CR,
  input  logic              time_active,
  input  logic              set_hour,
  input  logic              set_minute,
  input  logic              set_second,
  output logic [HOUR_W-1:0] hours_24,
  output logic [MIN_W-1:0]  minutes,
  output logic [SEC_W-1:0]  seconds,
  output logic [H12_W-1:0]  hours_12,
  output logic              pm,
  output logic              min_carry,
  output logic              chime
);

  localparam logic [SEC_W-1:0]  SEC_LIM  = SEC_W'(SEC_MAX);
  localparam logic [MIN_W-1:0]  MIN_LIM  = MIN_W'(MIN_MAX);
  localparam logic [HOUR_W-1:0] HOUR_LIM = HOUR_W'(HOUR_MAX);
  localparam logic [HOUR_W-1:0] NOON     = HOUR_W'(12);

  logic run;
  logic sec_inc, min_inc, hour_inc;
  logic sec_wrap, min_wrap, hour_wrap;
  logic sec_clr, min_clr, hour_clr;
  logic chime_trig;

  assign run = ~time_active;

  // In run mode carries ripple through the wraps; in set mode each button drives only its own field.
  assign sec_inc  = run | set_second;
  assign min_inc  = run ? sec_wrap : set_minute;
  assign hour_inc = run ? min_wrap : set_hour;

  // A field holding an illegal value is forced back to zero on the next edge.
  assign sec_clr  = CR | (seconds  > SEC_LIM);
  assign min_clr  = CR | (minutes  > MIN_LIM);
  assign hour_clr = CR | (hours_24 > HOUR_LIM);

  mod_counter #(.MAX(SEC_MAX), .W(SEC_W)) u_sec (
    .clk  (CP_1Hz),
    .clr  (sec_clr),
    .inc  (sec_inc),
    .q    (seconds),
    .wrap (sec_wrap)
  );

  mod_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
    .clk  (CP_1Hz),
    .clr  (min_clr),
    .inc  (min_inc),
    .q    (minutes),
    .wrap (min_wrap)
  );

  mod_counter #(.MAX(HOUR_MAX), .W(HOUR_W)) u_hour (
    .clk  (CP_1Hz),
    .clr  (hour_clr),
    .inc  (hour_inc),
    .q    (hours_24),
    .wrap (hour_wrap)
  );

  always_ff @(posedge CP_1Hz) begin
    if (CR) begin
      min_carry <= 1'b0;
    end else begin
      min_carry <= run & sec_wrap;
    end
  end

  always_comb begin
    hours_12 = hours_24[H12_W-1:0];
    if (hours_24 == '0) begin
      hours_12 = H12_W'(12);
    end else if (hours_24 > NOON) begin
      hours_12 = H12_W'(hours_24 - NOON);
    end
    pm = (hours_24 >= NOON);
  end

  // Only a counted xx:59:59 -> xx:00:00 edge triggers; hand-set 00:00 never does.
  assign chime_trig = run & min_wrap;

  generate
    if (CHIME_EN != 0) begin : g_chime
      localparam logic [3:0] CHIME_RELOAD = 4'(CHIME_LEN - 1);
      logic [3:0] chime_cnt;

      always_ff @(posedge CP_1Hz) begin
        if (CR || time_active) begin
          chime     <= 1'b0;
          chime_cnt <= '0;
        end else if (chime_trig) begin
          chime     <= 1'b1;
          chime_cnt <= CHIME_RELOAD;
        end else if (chime) begin
          if (chime_cnt != '0) begin
            chime_cnt <= chime_cnt - 4'd1;
          end else begin
            chime <= 1'b0;
          end
        end
      end
    end else begin : g_no_chime
      assign chime = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_time_counter.sv
// Randomized and directed bench for time_counter against a seconds-of-day reference model.
module tb_time_counter;
  import clock_pkg::*;

  localparam int CHIME_LEN = 5;
  localparam int EXP_W     = 24;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              cr = 1'b1;
  logic              ta = 1'b0;
  logic              sh = 1'b0;
  logic              sm = 1'b0;
  logic              ss = 1'b0;
  logic [HOUR_W-1:0] hours_24;
  logic [MIN_W-1:0]  minutes;
  logic [SEC_W-1:0]  seconds;
  logic [H12_W-1:0]  hours_12;
  logic              pm;
  logic              min_carry;
  logic              chime;

  time_counter #(.CHIME_LEN(CHIME_LEN), .CHIME_EN(1)) dut (
    .CP_1Hz      (clk),
    .CR          (cr),
    .time_active (ta),
    .set_hour    (sh),
    .set_minute  (sm),
    .set_second  (ss),
    .hours_24    (hours_24),
    .minutes     (minutes),
    .seconds     (seconds),
    .hours_12    (hours_12),
    .pm          (pm),
    .min_carry   (min_carry),
    .chime       (chime)
  );

  int checks = 0;
  int errors = 0;

  // reference model: time as seconds since midnight
  int t         = 0;
  int chime_rem = 0;
  bit carry_m   = 1'b0;
  logic [EXP_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [EXP_W-1:0] pack_model();
    int h, m, s, h12;
    h   = t / 3600;
    m   = (t / 60) % 60;
    s   = t % 60;
    h12 = (h % 12 == 0) ? 12 : h % 12;
    return {5'(h), 6'(m), 6'(s), 4'(h12), (h >= 12), carry_m, (chime_rem > 0)};
  endfunction

  task automatic model_edge(input bit r, input bit a, input bit bh, input bit bm, input bit bs);
    int h, m, s;
    if (r) begin
      t = 0; carry_m = 0; chime_rem = 0;
    end else if (a) begin
      h = t / 3600; m = (t / 60) % 60; s = t % 60;
      if (bh) h = (h + 1) % 24;
      if (bm) m = (m + 1) % 60;
      if (bs) s = (s + 1) % 60;
      t = h * 3600 + m * 60 + s;
      carry_m = 0; chime_rem = 0;
    end else begin
      carry_m = (t % 60 == 59);
      if (t % 3600 == 3599) chime_rem = CHIME_LEN;
      else if (chime_rem > 0) chime_rem--;
      t = (t + 1) % 86400;
    end
    exp_q.push_back(pack_model());
  endtask

  task automatic compare_outputs();
    logic [EXP_W-1:0] e;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check("hours_24",  hours_24,  e[23:19]);
    check("minutes",   minutes,   e[18:13]);
    check("seconds",   seconds,   e[12:7]);
    check("hours_12",  hours_12,  e[6:3]);
    check("pm",        pm,        e[2]);
    check("min_carry", min_carry, e[1]);
    check("chime",     chime,     e[0]);
  endtask

  // driver: inputs change on the falling edge, outputs sampled 1 time unit after the rising edge
  task automatic step(input bit r, input bit a, input bit bh, input bit bm, input bit bs);
    @(negedge clk);
    cr = r; ta = a; sh = bh; sm = bm; ss = bs;
    @(posedge clk);
    model_edge(r, a, bh, bm, bs);
    #1;
    compare_outputs();
  endtask

  task automatic preset(input int h, input int m, input int s);
    int n;
    step(1, 0, 0, 0, 0);
    n = (h > m) ? h : m;
    n = (n > s) ? n : s;
    for (int i = 0; i < n; i++) step(0, 1, i < h, i < m, i < s);
  endtask

  int hr_tab [6] = '{0, 1, 11, 12, 13, 23};
  int h12_tab[6] = '{12, 1, 11, 12, 1, 11};
  int pm_tab [6] = '{0, 0, 0, 1, 1, 1};

  initial begin
    // reset and free run to 00:01:01
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    check("t1_reset_time", {hours_24, minutes, seconds}, 0);
    for (int i = 1; i <= 61; i++) begin
      step(0, 0, 0, 0, 0);
      if (i == 60) check("t1_carry_high", min_carry, 1);
      if (i == 61) check("t1_carry_low", min_carry, 0);
    end
    check("t1_time", {hours_24, minutes, seconds}, {5'd0, 6'd1, 6'd1});

    // midnight rollover and chime length
    preset(23, 59, 58);
    step(0, 0, 0, 0, 0);
    check("t2_no_chime_yet", chime, 0);
    step(0, 0, 0, 0, 0);
    check("t2_midnight", {hours_24, minutes, seconds}, 0);
    check("t2_chime_on", chime, 1);
    for (int i = 0; i < CHIME_LEN - 1; i++) begin
      step(0, 0, 0, 0, 0);
      check("t2_chime_hold", chime, 1);
    end
    step(0, 0, 0, 0, 0);
    check("t2_chime_off", chime, 0);

    // set_second wraps without carrying
    preset(10, 59, 59);
    step(0, 1, 0, 0, 1);
    check("t3_time", {hours_24, minutes, seconds}, {5'd10, 6'd59, 6'd0});
    check("t3_chime", chime, 0);
    check("t3_carry", min_carry, 0);

    // all three buttons together
    preset(23, 59, 59);
    step(0, 1, 1, 1, 1);
    check("t4_time", {hours_24, minutes, seconds}, 0);
    check("t4_chime", chime, 0);

    // 12-hour decode sweep
    for (int k = 0; k < 6; k++) begin
      preset(hr_tab[k], 0, 0);
      check("t5_hours_12", hours_12, h12_tab[k]);
      check("t5_pm", pm, pm_tab[k]);
    end

    // reset and set mode abort an active chime
    preset(23, 59, 58);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
    check("t6_chime_mid", chime, 1);
    step(1, 0, 0, 0, 0);
    check("t6_reset_all", {hours_24, minutes, seconds, min_carry, chime}, 0);
    preset(23, 59, 58);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    check("t6_set_clears_chime", chime, 0);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0,
           1'($urandom), 1'($urandom), 1'($urandom));
    end
    for (int n = 0; n < 8; n++) begin
      preset($urandom_range(0, 23), 59, $urandom_range(50, 59));
      for (int i = 0; i < 12; i++) step(0, $urandom_range(0, 15) == 0, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
